spi_slave_sync: RTL and testbench

- System-clock-domain SPI responder: the target end of the link that spi_master initiates.
- spi_clk, cs_n and spi_i are treated as asynchronous inputs. They are oversampled on clk through synchronizers and edge-detected, unlike spi_slave, which is clocked directly by spi_clk.
- Presents each received WIDTH-bit word to on-chip logic with a valid pulse, and shifts out a word preloaded through a one-entry transmit buffer.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_slave_sync.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder oversampled on the system clock.
// Receives WIDTH-bit frames MSB first and replies from a one-entry tx buffer.
module spi_slave_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             cs_n,
  input  logic             spi_i,
  output logic             spi_o,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_wr,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             tx_underrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic cs_fall, cs_rise;

  state_e           state_q, state_d;
  logic [SW-1:0]    wait_q, wait_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] txbuf_q, txbuf_d;
  logic             txfull_q, txfull_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             underrun_q, underrun_d;
  logic             busy_q, busy_d;
  logic             spi_o_q, spi_o_d;
  logic             take;
  logic             wr_ok;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bitcnt_d    = bitcnt_q;
    shift_tx_d  = shift_tx_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;
    spi_o_d     = 1'b0;
    take        = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        // The synchronizer still holds reset values until it has been
        // flushed, so only trust cs_n once every stage saw the real pin.
        if (wait_q != SW'(SYNC_STAGES)) begin
          wait_d = wait_q + SW'(1);
        end else if (cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          take       = 1'b1;
          state_d    = ACTIVE;
          busy_d     = 1'b1;
          bitcnt_d   = '0;
          shift_tx_d = txfull_q ? txbuf_q : '0;
          underrun_d = ~txfull_q;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          frame_err_d = (bitcnt_q != CW'(WIDTH));
          state_d     = IDLE;
          busy_d      = 1'b0;
        end else begin
          spi_o_d = shift_tx_q[WIDTH-1];
          if (sclk_rise && bitcnt_q < CW'(WIDTH)) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
            bitcnt_d   = bitcnt_q + CW'(1);
            if (bitcnt_q == CW'(WIDTH - 1)) begin
              rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
              rx_valid_d = 1'b1;
            end
          end else if (sclk_fall && bitcnt_q < CW'(WIDTH)) begin
            shift_tx_d = {shift_tx_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase

    // A write coinciding with frame start lands after the old word leaves.
    wr_ok    = tx_wr & (~txfull_q | take);
    txbuf_d  = wr_ok ? tx_data : txbuf_q;
    txfull_d = wr_ok ? 1'b1 : (take ? 1'b0 : txfull_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      wait_q      <= '0;
      bitcnt_q    <= '0;
      shift_tx_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      txbuf_q     <= '0;
      txfull_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      spi_o_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bitcnt_q    <= bitcnt_d;
      shift_tx_q  <= shift_tx_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      txbuf_q     <= txbuf_d;
      txfull_q    <= txfull_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      spi_o_q     <= spi_o_d;
    end
  end

  assign spi_o       = spi_o_q;
  assign tx_ready    = ~txfull_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: directed vector table, hand sequences,
// and random frames checked against a queue-based reference model.
module tb_spi_slave_sync;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         spi_clk;
  logic         cs_n;
  logic         spi_i;
  logic         spi_o;
  logic [W-1:0] tx_data;
  logic         tx_wr;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;
  logic         tx_underrun;

  always #5 clk = ~clk;

  spi_slave_sync #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .cs_n       (cs_n),
    .spi_i      (spi_i),
    .spi_o      (spi_o),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .tx_underrun(tx_underrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int nvalid = 0;
  int nerr   = 0;
  int nunf   = 0;
  int nboth  = 0;

  always @(posedge clk) begin
    if (rx_valid) nvalid++;
    if (frame_err) nerr++;
    if (tx_underrun) nunf++;
    if (rx_valid && frame_err) nboth++;
  end

  typedef struct {
    bit          pre;
    logic [31:0] txw;
    logic [31:0] mosi;
    int          nbits;
    bit          rl;
    logic [31:0] rlw;
    logic [31:0] e_miso;
    logic [31:0] e_rx;
    int          e_v;
    int          e_err;
    int          e_unf;
    bit          e_ready;
  } vec_t;

  vec_t tv[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [31:0] w);
    tx_data = w;
    tx_wr   = 1'b1;
    cyc(1);
    tx_wr   = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] mosi, input int nbits,
                           input int rst_at, input bit reload,
                           input logic [31:0] rl_word,
                           output logic [31:0] miso);
    miso  = '0;
    cs_n  = 1'b0;
    spi_i = mosi[31];
    cyc(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      if (reload && i == 8) begin
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_tx_ready", 32'(tx_ready), 32'd1);
        tx_write(rl_word);
      end
      miso[31-i] = spi_o;
      spi_clk = 1'b1;
      cyc(4);
      spi_clk = 1'b0;
      if (i < 31) spi_i = mosi[30-i];
      cyc(4);
    end
    cs_n = 1'b1;
    cyc(8);
  endtask

  logic [31:0] miso;
  logic [31:0] mask;
  logic [31:0] w;
  logic [31:0] mosi_r;
  logic [31:0] e_miso;
  logic [31:0] mdl_rx;
  logic [31:0] mq[$];
  int          v0, e0, u0;
  int          nb;
  bit          e_unf;

  initial begin
    tv[0] = '{1, 32'hA5A5_5A5A, 32'h1234_5678, 32, 0, 32'h0,
              32'hA5A5_5A5A, 32'h1234_5678, 1, 0, 0, 1};
    tv[1] = '{0, 32'h0, 32'hCAFE_F00D, 32, 0, 32'h0,
              32'h0000_0000, 32'hCAFE_F00D, 1, 0, 1, 1};
    tv[2] = '{1, 32'hF00D_1234, 32'h55AA_0000, 16, 0, 32'h0,
              32'hF00D_0000, 32'hCAFE_F00D, 0, 1, 0, 1};
    tv[3] = '{1, 32'h0000_FFFF, 32'h8765_4321, 32, 1, 32'hDEAD_BEEF,
              32'h0000_FFFF, 32'h8765_4321, 1, 0, 0, 0};
    tv[4] = '{0, 32'h0, 32'h1234_5678, 32, 0, 32'h0,
              32'hDEAD_BEEF, 32'h1234_5678, 1, 0, 0, 1};

    rst     = 1'b1;
    cs_n    = 1'b1;
    spi_clk = 1'b0;
    spi_i   = 1'b0;
    tx_wr   = 1'b0;
    tx_data = '0;
    cyc(3);
    check("rst_spi_o", 32'(spi_o), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    rst = 1'b0;
    cyc(8);

    for (int i = 0; i < 5; i++) begin
      v0 = nvalid; e0 = nerr; u0 = nunf;
      if (tv[i].pre) tx_write(tv[i].txw);
      spi_frame(tv[i].mosi, tv[i].nbits, -1, tv[i].rl, tv[i].rlw, miso);
      check($sformatf("vec%0d_miso", i), miso, tv[i].e_miso);
      check($sformatf("vec%0d_rx_data", i), rx_data, tv[i].e_rx);
      check($sformatf("vec%0d_rx_valid_cnt", i), nvalid - v0, tv[i].e_v);
      check($sformatf("vec%0d_frame_err_cnt", i), nerr - e0, tv[i].e_err);
      check($sformatf("vec%0d_underrun_cnt", i), nunf - u0, tv[i].e_unf);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_spi_o_idle", i), 32'(spi_o), 32'd0);
      check($sformatf("vec%0d_tx_ready", i), 32'(tx_ready),
            32'(tv[i].e_ready));
    end

    // reset in the middle of a frame
    tx_write(32'h3333_3333);
    v0 = nvalid; e0 = nerr; u0 = nunf;
    spi_frame(32'h8765_4321, 32, 10, 0, 32'h0, miso);
    check("rstmid_rx_valid_cnt", nvalid - v0, 0);
    check("rstmid_frame_err_cnt", nerr - e0, 0);
    check("rstmid_underrun_cnt", nunf - u0, 0);
    check("rstmid_rx_data", rx_data, 32'h0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tx_ready", 32'(tx_ready), 32'd1);
    v0 = nvalid; u0 = nunf;
    spi_frame(32'h1234_5678, 32, -1, 0, 32'h0, miso);
    check("postrst_rx_data", rx_data, 32'h1234_5678);
    check("postrst_rx_valid_cnt", nvalid - v0, 1);
    check("postrst_underrun_cnt", nunf - u0, 1);
    check("postrst_miso", miso, 32'h0);

    // second write while buffer full is dropped
    tx_write(32'h1111_1111);
    tx_write(32'h2222_2222);
    check("coll_tx_ready", 32'(tx_ready), 32'd0);
    spi_frame(32'h0BAD_F00D, 32, -1, 0, 32'h0, miso);
    check("coll_miso", miso, 32'h1111_1111);
    check("coll_rx_data", rx_data, 32'h0BAD_F00D);
    check("coll_tx_ready_after", 32'(tx_ready), 32'd1);

    // random frames against the reference model
    mdl_rx = 32'h0BAD_F00D;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(2) != 0) begin
        w = $urandom;
        tx_write(w);
        if (mq.size() == 0) mq.push_back(w);
      end
      if ($urandom_range(3) == 0) begin
        w = $urandom;
        tx_write(w);
        if (mq.size() == 0) mq.push_back(w);
      end
      mosi_r = $urandom;
      nb     = ($urandom_range(3) == 0) ? int'($urandom_range(1, 31)) : 32;
      e_unf  = (mq.size() == 0);
      e_miso = e_unf ? 32'h0 : mq.pop_front();
      mask   = '1;
      mask   = mask << (32 - nb);
      if (nb == 32) mdl_rx = mosi_r;
      v0 = nvalid; e0 = nerr; u0 = nunf;
      spi_frame(mosi_r, nb, -1, 0, 32'h0, miso);
      check($sformatf("rnd%0d_miso", k), miso, e_miso & mask);
      check($sformatf("rnd%0d_rx_data", k), rx_data, mdl_rx);
      check($sformatf("rnd%0d_rx_valid_cnt", k), nvalid - v0,
            (nb == 32) ? 1 : 0);
      check($sformatf("rnd%0d_frame_err_cnt", k), nerr - e0,
            (nb == 32) ? 0 : 1);
      check($sformatf("rnd%0d_underrun_cnt", k), nunf - u0, 32'(e_unf));
      check($sformatf("rnd%0d_tx_ready", k), 32'(tx_ready),
            32'(mq.size() == 0));
    end

    check("no_valid_err_overlap", nboth, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
